// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port word memory between the CPU and a secondary (DMA) master.
// Accesses are serialized through IDLE -> ISSUE -> [WAIT] -> DONE with registered strobes and acks.
module mem_port_arbiter #(
  parameter int DW         = 16,
  parameter int AW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int CPU_PRIO   = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_dma
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
  localparam logic [1:0] WAIT_INIT  = 2'(MEM_LAT - 1);

  state_t        state_q;
  logic          we_q;
  logic [1:0]    wait_q;
  logic [3:0]    starve_q;
  logic          rr_last_q;
  logic          gnt_dma_q;
  logic          cpu_ack_q;
  logic          dma_ack_q;
  logic          mem_rd_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;

  logic          req_any_d;
  logic          pick_dma_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  // Tie-break: fixed CPU priority with starvation relief, or alternate against the last grant.
  always_comb begin
    req_any_d  = cpu_req | dma_req;
    pick_dma_d = dma_req;
    if (cpu_req && dma_req) begin
      if (CPU_PRIO != 0) pick_dma_d = (starve_q >= STARVE_MAX);
      else               pick_dma_d = ~rr_last_q;
    end
    sel_we_d    = pick_dma_d ? dma_we    : cpu_we;
    sel_addr_d  = pick_dma_d ? dma_addr  : cpu_addr;
    sel_wdata_d = pick_dma_d ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      wait_q      <= '0;
      starve_q    <= '0;
      rr_last_q   <= 1'b1;
      gnt_dma_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!dma_req || pick_dma_d)   starve_q <= '0;
          else if (CPU_PRIO != 0)       starve_q <= starve_q + 4'd1;
          if (req_any_d) begin
            gnt_dma_q  <= pick_dma_d;
            rr_last_q  <= pick_dma_d;
            we_q       <= sel_we_d;
            mem_addr_q <= sel_addr_d;
            if (sel_we_d) begin
              mem_wdata_q <= sel_wdata_d;
              mem_wr_q    <= 1'b1;
            end else begin
              mem_rd_q    <= 1'b1;
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (we_q) begin
            mem_wr_q  <= 1'b0;
            cpu_ack_q <= ~gnt_dma_q;
            dma_ack_q <= gnt_dma_q;
            state_q   <= S_DONE;
          end else begin
            wait_q  <= WAIT_INIT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_q == 2'd0) begin
            rdata_q   <= mem_rdata;
            mem_rd_q  <= 1'b0;
            cpu_ack_q <= ~gnt_dma_q;
            dma_ack_q <= gnt_dma_q;
            state_q   <= S_DONE;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        default: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign gnt_dma   = gnt_dma_q;

endmodule
